// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory stage: EX/MEM and MEM/WB field
// positions, handshake FSM encoding and the aborted-load data value.
package mem_stage_pkg;

  localparam int EXMEM_W        = 38;
  localparam int MEMWB_W        = 21;

  localparam int EXMEM_ADDR_HI  = 37;
  localparam int EXMEM_ADDR_LO  = 22;
  localparam int EXMEM_MEMW     = 21;
  localparam int EXMEM_WDATA_HI = 20;
  localparam int EXMEM_WDATA_LO = 5;
  localparam int EXMEM_WB       = 4;
  localparam int EXMEM_DEST_HI  = 3;
  localparam int EXMEM_DEST_LO  = 1;
  localparam int EXMEM_LOAD     = 0;

  localparam int MEMWB_VAL_HI   = 20;
  localparam int MEMWB_VAL_LO   = 5;

  localparam logic [15:0] LOAD_ERR_DEFAULT = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } hs_state_t;

endpackage

// File: rtl/mem_stage_dmem_handshake.sv
// Data-memory req/ack handshake: access FSM, captured load data and, when
// MEM_TIMEOUT_EN is defined, the request timeout with a sticky error flag.
module dmem_handshake
  import mem_stage_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [15:0] LOAD_ERR_VALUE = LOAD_ERR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        mem_op,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_req,
  output logic        stall_out,
  output logic [15:0] load_data,
  output logic        mem_err
);

`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  hs_state_t        state;
  logic [15:0]      cap;
  logic [CNT_W-1:0] cnt;
  logic             tmo_hit;
  logic             ack_eff;
  logic             live;
  logic [15:0]      rdata_eff;

  // A timeout stands in for the ack so the pipeline drains with error data.
  assign tmo_hit   = TMO_EN && (state == WAIT) && (cnt == TMO_LAST);
  assign ack_eff   = dmem_ack | tmo_hit;
  assign live      = mem_op & (state != DONE);
  assign rdata_eff = tmo_hit ? LOAD_ERR_VALUE : dmem_rdata;
  assign load_data = (live & ack_eff) ? rdata_eff : cap;

  // Reset gates the request and freeze so an in-flight access drops at once.
  assign stall_out = rst & live & ~ack_eff;
  assign dmem_req  = rst & (((state == IDLE) & mem_op) | ((state == WAIT) & ~tmo_hit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cap   <= '0;
    end else begin
      case (state)
        IDLE: if (mem_op) begin
          if (dmem_ack) begin
            cap   <= dmem_rdata;
            state <= stall_in ? DONE : IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (ack_eff) begin
          cap   <= rdata_eff;
          state <= stall_in ? DONE : IDLE;
        end
        DONE: if (!stall_in) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      cnt <= (state == WAIT && !ack_eff) ? cnt + 1'b1 : '0;
      if (tmo_hit) mem_err <= 1'b1;
    end
  end
`else
  assign cnt     = '0;
  assign mem_err = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory stage: slices the EX/MEM bus, drives the data-memory handshake and
// registers MEM/WB. Optional request timeout enabled by MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [15:0] LOAD_ERR_VALUE = LOAD_ERR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic [EXMEM_W-1:0] pipline_reg_in,
  output logic [MEMWB_W-1:0] pipline_reg_out,
  output logic [15:0]        Mem_data,
  output logic [2:0]         mem_op_dest,
  output logic               stall_out,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [15:0]        dmem_addr,
  output logic [15:0]        dmem_wdata,
  input  logic [15:0]        dmem_rdata,
  input  logic               dmem_ack,
  output logic               mem_err
);

  logic [15:0] addr;
  logic        mem_op;
  logic        is_load;
  logic [15:0] load_data;
  logic [15:0] wb_val;

  assign addr    = pipline_reg_in[EXMEM_ADDR_HI:EXMEM_ADDR_LO];
  assign mem_op  = pipline_reg_in[EXMEM_MEMW] | pipline_reg_in[EXMEM_LOAD];
  // Both access bits set resolves to a store.
  assign is_load = pipline_reg_in[EXMEM_LOAD] & ~pipline_reg_in[EXMEM_MEMW];

  assign Mem_data    = addr;
  assign mem_op_dest = pipline_reg_in[EXMEM_WB] ? pipline_reg_in[EXMEM_DEST_HI:EXMEM_DEST_LO] : 3'b0;
  assign dmem_we     = pipline_reg_in[EXMEM_MEMW];
  assign dmem_addr   = addr;
  assign dmem_wdata  = pipline_reg_in[EXMEM_WDATA_HI:EXMEM_WDATA_LO];
  assign wb_val      = is_load ? load_data : addr;

  dmem_handshake #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .LOAD_ERR_VALUE (LOAD_ERR_VALUE)
  ) u_hs (
    .clk        (clk),
    .rst        (rst),
    .stall_in   (stall_in),
    .mem_op     (mem_op),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .dmem_req   (dmem_req),
    .stall_out  (stall_out),
    .load_data  (load_data),
    .mem_err    (mem_err)
  );

  // MEM/WB boundary: external freeze wins over bubble insertion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipline_reg_out <= '0;
    end else if (!stall_in) begin
      pipline_reg_out <= stall_out ? '0 : {wb_val, pipline_reg_in[EXMEM_WB:EXMEM_LOAD]};
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB words are queued as each
// cycle's stimulus is applied and compared after the capturing edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic [37:0] pipline_reg_in;
  logic [20:0] pipline_reg_out;
  logic [15:0] Mem_data;
  logic [2:0]  mem_op_dest;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_reqs   = 0;
  logic [20:0] sb[$];
  logic [20:0] last_exp = '0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4), .LOAD_ERR_VALUE(16'hDEAD)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .pipline_reg_in  (pipline_reg_in),
    .pipline_reg_out (pipline_reg_out),
    .Mem_data        (Mem_data),
    .mem_op_dest     (mem_op_dest),
    .stall_out       (stall_out),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .mem_err         (mem_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [37:0] bus(input logic [15:0] a, input logic we, input logic [15:0] wd,
                                      input logic wb, input logic [2:0] dst, input logic ld);
    return {a, we, wd, wb, dst, ld};
  endfunction

  function automatic logic [20:0] wbw(input logic [15:0] v, input logic wb,
                                      input logic [2:0] dst, input logic ld);
    return {v, wb, dst, ld};
  endfunction

  // One clock: queue the expected word if the register updates, else expect a hold.
  task automatic tick(input string tag, input bit upd, input logic [20:0] exp);
    if (upd) sb.push_back(exp);
    if (dmem_req && dmem_ack) n_reqs++;
    @(posedge clk); #1;
    if (upd) begin
      last_exp = sb.pop_front();
      check_eq(tag, 32'(pipline_reg_out), 32'(last_exp));
    end else begin
      check_eq({tag, "_hold"}, 32'(pipline_reg_out), 32'(last_exp));
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [37:0] b, input logic ack, input logic [15:0] rd, input logic stl);
    pipline_reg_in = b;
    dmem_ack       = ack;
    dmem_rdata     = rd;
    stall_in       = stl;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive('0, 1'b0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_out", 32'(pipline_reg_out), 32'h0);
    check_eq("rst_req", 32'(dmem_req), 32'h0);
    check_eq("rst_stall", 32'(stall_out), 32'h0);
    check_eq("rst_err", 32'(mem_err), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // ALU op passes straight through.
    drive(bus(16'h1234, 1'b0, 16'h0, 1'b1, 3'd3, 1'b0), 1'b0, 16'h0, 1'b0);
    check_eq("alu_dest", 32'(mem_op_dest), 32'd3);
    check_eq("alu_fwd", 32'(Mem_data), 32'h1234);
    check_eq("alu_req", 32'(dmem_req), 32'h0);
    check_eq("alu_stall", 32'(stall_out), 32'h0);
    tick("alu_out", 1'b1, wbw(16'h1234, 1'b1, 3'd3, 1'b0));

    drive(bus(16'h7777, 1'b0, 16'h0, 1'b0, 3'd5, 1'b0), 1'b0, 16'h0, 1'b0);
    check_eq("nowb_dest", 32'(mem_op_dest), 32'd0);
    tick("nowb_out", 1'b1, wbw(16'h7777, 1'b0, 3'd5, 1'b0));

    // Zero-wait load.
    drive(bus(16'h0040, 1'b0, 16'h0, 1'b1, 3'd2, 1'b1), 1'b1, 16'hBEEF, 1'b0);
    check_eq("ld0_req", 32'(dmem_req), 32'h1);
    check_eq("ld0_we", 32'(dmem_we), 32'h0);
    check_eq("ld0_addr", 32'(dmem_addr), 32'h0040);
    check_eq("ld0_stall", 32'(stall_out), 32'h0);
    tick("ld0_out", 1'b1, wbw(16'hBEEF, 1'b1, 3'd2, 1'b1));

    // Store acked on the fourth request cycle: three bubbles, then the store.
    n_reqs = 0;
    for (int i = 0; i < 3; i++) begin
      drive(bus(16'h0010, 1'b1, 16'h00AA, 1'b0, 3'd0, 1'b0), 1'b0, 16'h0, 1'b0);
      check_eq($sformatf("st_req%0d", i), 32'(dmem_req), 32'h1);
      check_eq($sformatf("st_we%0d", i), 32'(dmem_we), 32'h1);
      check_eq($sformatf("st_stall%0d", i), 32'(stall_out), 32'h1);
      tick($sformatf("st_bub%0d", i), 1'b1, 21'h0);
    end
    drive(bus(16'h0010, 1'b1, 16'h00AA, 1'b0, 3'd0, 1'b0), 1'b1, 16'h0, 1'b0);
    check_eq("st_wdata", 32'(dmem_wdata), 32'h00AA);
    check_eq("st_ack_stall", 32'(stall_out), 32'h0);
    tick("st_out", 1'b1, wbw(16'h0010, 1'b0, 3'd0, 1'b0));
    drive('0, 1'b0, 16'h0, 1'b0);
    check_eq("st_noreissue", 32'(dmem_req), 32'h0);
    check_eq("st_acks", 32'(n_reqs), 32'd1);
    tick("nop0", 1'b1, 21'h0);

    // Both access bits set: treated as a store, writes back the address.
    drive(bus(16'h0020, 1'b1, 16'h1111, 1'b1, 3'd4, 1'b1), 1'b1, 16'h9999, 1'b0);
    check_eq("both_we", 32'(dmem_we), 32'h1);
    tick("both_out", 1'b1, wbw(16'h0020, 1'b1, 3'd4, 1'b1));

    // Load acked while frozen: holds in DONE, no second request.
    drive(bus(16'h0080, 1'b0, 16'h0, 1'b1, 3'd6, 1'b1), 1'b1, 16'h5555, 1'b1);
    check_eq("frz_req", 32'(dmem_req), 32'h1);
    tick("frz0", 1'b0, 21'h0);
    drive(bus(16'h0080, 1'b0, 16'h0, 1'b1, 3'd6, 1'b1), 1'b0, 16'h0, 1'b1);
    check_eq("frz_done_req", 32'(dmem_req), 32'h0);
    check_eq("frz_done_stall", 32'(stall_out), 32'h0);
    tick("frz1", 1'b0, 21'h0);
    drive(bus(16'h0080, 1'b0, 16'h0, 1'b1, 3'd6, 1'b1), 1'b0, 16'h0, 1'b0);
    tick("frz_out", 1'b1, wbw(16'h5555, 1'b1, 3'd6, 1'b1));

    // Reset in WAIT abandons the access immediately.
    drive(bus(16'h0100, 1'b0, 16'h0, 1'b1, 3'd1, 1'b1), 1'b0, 16'h0, 1'b0);
    tick("rw_bub", 1'b1, 21'h0);
    drive(bus(16'h0100, 1'b0, 16'h0, 1'b1, 3'd1, 1'b1), 1'b0, 16'h0, 1'b0);
    check_eq("rw_wait_stall", 32'(stall_out), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("rw_req", 32'(dmem_req), 32'h0);
    check_eq("rw_stall", 32'(stall_out), 32'h0);
    check_eq("rw_out", 32'(pipline_reg_out), 32'h0);
    @(negedge clk);
    drive('0, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    last_exp = '0;
    check_eq("rw_idle_req", 32'(dmem_req), 32'h0);
    tick("rw_nop", 1'b1, 21'h0);

`ifdef MEM_TIMEOUT_EN
    // Unacked load: request cycle plus four WAIT cycles, last one aborts.
    for (int i = 0; i < 4; i++) begin
      drive(bus(16'h0200, 1'b0, 16'h0, 1'b1, 3'd7, 1'b1), 1'b0, 16'h0, 1'b0);
      check_eq($sformatf("to_stall%0d", i), 32'(stall_out), 32'h1);
      tick($sformatf("to_bub%0d", i), 1'b1, 21'h0);
    end
    drive(bus(16'h0200, 1'b0, 16'h0, 1'b1, 3'd7, 1'b1), 1'b0, 16'h0, 1'b0);
    check_eq("to_req_drop", 32'(dmem_req), 32'h0);
    tick("to_out", 1'b1, wbw(16'hDEAD, 1'b1, 3'd7, 1'b1));
    check_eq("to_err", 32'(mem_err), 32'h1);
    drive('0, 1'b0, 16'h0, 1'b0);
    tick("to_nop", 1'b1, 21'h0);
    check_eq("to_err_sticky", 32'(mem_err), 32'h1);
`else
    check_eq("err_tied", 32'(mem_err), 32'h0);
`endif

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
